// File: rtl/tx_work_sched.sv
// Transmit work scheduler: moves one complete work packet from the TX FIFO to the
// serializer word by word, then arms tx_timer and waits for it to release.
module tx_work_sched #(
    parameter int WORK_WORDS = 23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_flush,
    input  logic        reg_enable,
    input  logic [31:0] reg_tout,
    input  logic [9:0]  fifo_count,
    output logic        fifo_rd_en,
    input  logic [31:0] fifo_dout,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic        timer_start,
    input  logic        timer_busy,
    output logic        sched_busy,
    output logic [31:0] work_cnt
);

    localparam int IW = (WORK_WORDS > 1) ? $clog2(WORK_WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORK_WORDS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_ARM   = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;
    localparam logic [2:0] S_WAIT  = 3'd6;

    logic [2:0]    r_state;
    logic [IW-1:0] r_idx;
    logic [31:0]   r_tx_data;
    logic          r_tx_valid;
    logic [31:0]   r_work_cnt;

    logic w_start;
    logic w_hs;
    logic w_at_last;
    logic w_tout_nz;
    logic w_unused_tout;

    assign w_start       = reg_enable && !timer_busy && (fifo_count >= 10'(WORK_WORDS));
    assign w_hs          = r_tx_valid && tx_ready;
    assign w_at_last     = (r_idx == LAST_IDX);
    // tx_timer hangs busy forever on a zero timeout, so that case bypasses ARM/HOLD/WAIT
    assign w_tout_nz     = (reg_tout[23:0] != 24'd0);
    assign w_unused_tout = ^reg_tout[31:24];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_work_cnt <= '0;
        end else if (reg_flush) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_LOAD;
                        r_idx   <= '0;
                    end
                end
                S_LOAD:  r_state <= S_FETCH;
                S_FETCH: begin
                    r_tx_data  <= fifo_dout;
                    r_tx_valid <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    if (w_hs) begin
                        r_tx_valid <= 1'b0;
                        if (w_at_last) begin
                            r_work_cnt <= r_work_cnt + 32'd1;
                            r_state    <= w_tout_nz ? S_ARM : S_IDLE;
                        end else begin
                            r_idx   <= r_idx + IW'(1);
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_ARM:  r_state <= S_HOLD;
                S_HOLD: r_state <= S_WAIT;
                S_WAIT: begin
                    if (!timer_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign fifo_rd_en  = (r_state == S_LOAD);
    assign timer_start = (r_state == S_ARM);
    assign sched_busy  = (r_state != S_IDLE);
    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign tx_last     = r_tx_valid && w_at_last;
    assign work_cnt    = r_work_cnt;

endmodule

// File: tb/tb_tx_work_sched.sv
// Directed bench for tx_work_sched (WORK_WORDS=4) with a behavioural FIFO and tx_timer.
module tb_tx_work_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_flush;
    logic        reg_enable;
    logic [31:0] reg_tout;
    logic [9:0]  fifo_count;
    logic        fifo_rd_en;
    logic [31:0] fifo_dout;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic        timer_start;
    logic        timer_busy;
    logic        sched_busy;
    logic [31:0] work_cnt;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned n_valid = 0;
    int unsigned tcnt    = 0;

    logic [31:0] fq[$];
    logic [31:0] hs_data[$];
    logic        hs_last[$];
    int unsigned hs_cyc[$];
    int unsigned rd_cyc[$];
    int unsigned ts_cyc[$];
    int unsigned fall_q[$];

    tx_work_sched #(.WORK_WORDS(4)) dut (
        .clk(clk), .rst(rst), .reg_flush(reg_flush), .reg_enable(reg_enable),
        .reg_tout(reg_tout), .fifo_count(fifo_count), .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_last(tx_last), .timer_start(timer_start),
        .timer_busy(timer_busy), .sched_busy(sched_busy), .work_cnt(work_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO with one-cycle read latency, tx_timer model, and event logging
    always @(negedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout = (fq.size() > 0) ? fq.pop_front() : 32'hDEAD_DEAD;
            rd_cyc.push_back(cyc);
        end
        fifo_count = 10'(fq.size());
        if (tx_valid) n_valid++;
        if (tx_valid && tx_ready) begin
            hs_data.push_back(tx_data);
            hs_last.push_back(tx_last);
            hs_cyc.push_back(cyc);
        end
        if (timer_start) begin
            ts_cyc.push_back(cyc);
            if (reg_tout[23:0] != 24'd0) begin
                timer_busy = 1'b1;
                tcnt = reg_tout;
            end
        end else if (timer_busy) begin
            tcnt--;
            if (tcnt == 0) begin
                timer_busy = 1'b0;
                fall_q.push_back(cyc);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        fq.push_back(w);
    endtask

    task automatic wait_done(input logic [31:0] exp_cnt, input string tag);
        int unsigned n = 0;
        while (!(work_cnt == exp_cnt && !sched_busy && !timer_busy) && n < 400) begin
            step();
            n++;
        end
        check({tag, "_cnt"}, work_cnt, exp_cnt);
        check({tag, "_idle"}, 32'(sched_busy), 32'd0);
    endtask

    task automatic wait_word(input logic [31:0] w, input string tag);
        int unsigned n = 0;
        while (!(tx_valid && tx_data == w) && n < 60) begin
            step();
            n++;
        end
        check(tag, tx_data, w);
    endtask

    initial begin
        int unsigned c0, b_hs, b_rd, b_ts, b_f, nv0;
        rst = 1'b1; reg_flush = 1'b0; reg_enable = 1'b0; reg_tout = 32'd10;
        fifo_count = '0; fifo_dout = '0; tx_ready = 1'b1; timer_busy = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_valid", 32'(tx_valid), 0);
        check("rst_last", 32'(tx_last), 0);
        check("rst_rd", 32'(fifo_rd_en), 0);
        check("rst_ts", 32'(timer_start), 0);
        check("rst_busy", 32'(sched_busy), 0);
        check("rst_data", tx_data, 0);
        check("rst_cnt", work_cnt, 0);

        // basic packet
        for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
        step(); step();
        b_hs = hs_data.size(); b_rd = rd_cyc.size(); b_ts = ts_cyc.size(); nv0 = n_valid;
        reg_enable = 1'b1;
        c0 = cyc;
        wait_done(1, "t1");
        check("t1_nhs", 32'(hs_data.size() - b_hs), 4);
        for (int i = 0; i < 4; i++) begin
            check("t1_data", hs_data[b_hs+i], 32'hA0 + 32'(i));
            check("t1_last", 32'(hs_last[b_hs+i]), 32'(i == 3));
            if (i > 0) check("t1_space", hs_cyc[b_hs+i] - hs_cyc[b_hs+i-1], 3);
        end
        check("t1_rd_lat", rd_cyc[b_rd], c0 + 1);
        check("t1_vld_lat", hs_cyc[b_hs], c0 + 3);
        check("t1_nrd", 32'(rd_cyc.size() - b_rd), 4);
        check("t1_nvalid", n_valid - nv0, 4);
        check("t1_nts", 32'(ts_cyc.size() - b_ts), 1);
        check("t1_ts_cyc", ts_cyc[b_ts], hs_cyc[b_hs+3] + 1);

        // backpressure on word 2
        b_hs = hs_data.size(); b_rd = rd_cyc.size();
        for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
        wait_word(32'hA2, "t2_reach");
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_hold_v", 32'(tx_valid), 1);
            check("t2_hold_d", tx_data, 32'hA2);
        end
        tx_ready = 1'b1;
        wait_done(2, "t2");
        check("t2_nrd", 32'(rd_cyc.size() - b_rd), 4);
        check("t2_nhs", 32'(hs_data.size() - b_hs), 4);
        for (int i = 0; i < 4; i++) check("t2_data", hs_data[b_hs+i], 32'hA0 + 32'(i));

        // insufficient data
        b_rd = rd_cyc.size();
        for (int i = 0; i < 3; i++) push(32'hB0 + 32'(i));
        repeat (10) step();
        check("t3_nord", 32'(rd_cyc.size() - b_rd), 0);
        check("t3_idle", 32'(sched_busy), 0);
        push(32'hB3);
        c0 = cyc;
        wait_done(3, "t3");
        check("t3_rd_cyc", rd_cyc[b_rd], c0 + 1);

        // timer gating, two packets
        reg_tout = 32'd20;
        b_hs = hs_data.size(); b_rd = rd_cyc.size(); b_ts = ts_cyc.size(); b_f = fall_q.size();
        for (int i = 0; i < 8; i++) push(32'hC0 + 32'(i));
        wait_done(5, "t4");
        check("t4_nts", 32'(ts_cyc.size() - b_ts), 2);
        check("t4_nhs", 32'(hs_data.size() - b_hs), 8);
        check("t4_gate", rd_cyc[b_rd+4], fall_q[b_f] + 2);
        check("t4_d7", hs_data[b_hs+7], 32'hC7);

        // flush during SEND of word 1
        reg_tout = 32'd10;
        b_ts = ts_cyc.size();
        for (int i = 0; i < 4; i++) push(32'hD0 + 32'(i));
        wait_word(32'hD1, "t5_reach");
        tx_ready = 1'b0;
        reg_flush = 1'b1;
        fq.delete();
        step();
        reg_flush = 1'b0;
        check("t5_valid", 32'(tx_valid), 0);
        check("t5_idle", 32'(sched_busy), 0);
        check("t5_cnt", work_cnt, 5);
        repeat (5) step();
        check("t5_nts", 32'(ts_cyc.size() - b_ts), 0);
        tx_ready = 1'b1;

        // flush coincident with the last handshake
        for (int i = 0; i < 4; i++) push(32'hE0 + 32'(i));
        wait_word(32'hE3, "t6_reach");
        check("t6_last", 32'(tx_last), 1);
        reg_flush = 1'b1;
        step();
        reg_flush = 1'b0;
        check("t6_cnt", work_cnt, 5);
        check("t6_valid", 32'(tx_valid), 0);
        repeat (4) step();
        check("t6_nts", 32'(ts_cyc.size() - b_ts), 0);
        check("t6_idle", 32'(sched_busy), 0);

        // zero timeout bypasses the timer
        reg_tout = 32'd0;
        b_hs = hs_data.size(); b_rd = rd_cyc.size(); b_ts = ts_cyc.size();
        for (int i = 0; i < 8; i++) push(32'hF0 + 32'(i));
        wait_done(7, "t7");
        check("t7_nts", 32'(ts_cyc.size() - b_ts), 0);
        check("t7_nhs", 32'(hs_data.size() - b_hs), 8);
        check("t7_back2back", rd_cyc[b_rd+4], hs_cyc[b_hs+3] + 2);
        for (int i = 0; i < 8; i++) check("t7_data", hs_data[b_hs+i], 32'hF0 + 32'(i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
